mag_com_4bit: RTL and testbench



---
 rtl/mag_com_4bit_if.sv | 18 +
 rtl/mag_com_4bit.sv | 69 ++++++
 tb/tb_mag_com_4bit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mag_com_4bit_if.sv
`default_nettype none
// ============================================================================
//  mag_com_4bit_if : operand / result bundle for the magnitude comparator
//  Rev 1.0
// ============================================================================
interface mag_com_4bit_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             E;
    logic             G;
    logic             L;

    modport master (output A, output B, input  E, input  G, input  L);
    modport slave  (input  A, input  B, output E, output G, output L);
endinterface
`default_nettype wire

// File: rtl/mag_com_4bit.sv
`default_nettype none
// ============================================================================
//  mag_com_4bit : registered one-hot magnitude comparator (unsigned / signed)
//  Rev 1.0
// ============================================================================
module mag_com_4bit #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mag_com_4bit_if.slave  cmp_if
);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH:0]   w_heq;
    logic [WIDTH:0]   w_gt_acc;
    logic [WIDTH:0]   w_lt_acc;

    logic E_d, G_d, L_d;
    logic E_q, G_q, L_q;

    assign w_x = ~(cmp_if.A ^ cmp_if.B);

    // Chain seeds sit above the MSB: "all higher bits equal", nothing decided yet.
    assign w_heq[WIDTH]    = 1'b1;
    assign w_gt_acc[WIDTH] = 1'b0;
    assign w_lt_acc[WIDTH] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic w_a_wins;
        logic w_b_wins;

        // In two's complement a clear sign bit is the larger value at the MSB.
        if (SIGNED && (i == WIDTH - 1)) begin : g_sign_msb
            assign w_a_wins = ~cmp_if.A[i] &  cmp_if.B[i];
            assign w_b_wins =  cmp_if.A[i] & ~cmp_if.B[i];
        end else begin : g_mag_bit
            assign w_a_wins =  cmp_if.A[i] & ~cmp_if.B[i];
            assign w_b_wins = ~cmp_if.A[i] &  cmp_if.B[i];
        end

        assign w_heq[i]    = w_heq[i+1] & w_x[i];
        assign w_gt_acc[i] = w_gt_acc[i+1] | (w_heq[i+1] & w_a_wins);
        assign w_lt_acc[i] = w_lt_acc[i+1] | (w_heq[i+1] & w_b_wins);
    end

    assign E_d = w_heq[0];
    assign G_d = w_gt_acc[0];
    assign L_d = w_lt_acc[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E_q <= 1'b0;
            G_q <= 1'b0;
            L_q <= 1'b0;
        end else begin
            E_q <= E_d;
            G_q <= G_d;
            L_q <= L_d;
        end
    end

    assign cmp_if.E = E_q;
    assign cmp_if.G = G_q;
    assign cmp_if.L = L_q;

endmodule
`default_nettype wire

// File: tb/tb_mag_com_4bit.sv
`default_nettype none
// ============================================================================
//  tb_mag_com_4bit : directed + random checks of mag_com_4bit (4u, 4s, 8u)
//  Rev 1.0
// ============================================================================
module tb_mag_com_4bit;

    localparam logic [2:0] c_E    = 3'b100;
    localparam logic [2:0] c_G    = 3'b010;
    localparam logic [2:0] c_L    = 3'b001;
    localparam logic [2:0] c_NONE = 3'b000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mag_com_4bit_if #(.WIDTH(4)) bus_u4 ();
    mag_com_4bit_if #(.WIDTH(4)) bus_s4 ();
    mag_com_4bit_if #(.WIDTH(8)) bus_u8 ();

    mag_com_4bit #(.WIDTH(4), .SIGNED(1'b0)) u_dut_u4 (.clk(clk), .rst_n(rst_n), .cmp_if(bus_u4));
    mag_com_4bit #(.WIDTH(4), .SIGNED(1'b1)) u_dut_s4 (.clk(clk), .rst_n(rst_n), .cmp_if(bus_s4));
    mag_com_4bit #(.WIDTH(8), .SIGNED(1'b0)) u_dut_u8 (.clk(clk), .rst_n(rst_n), .cmp_if(bus_u8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got EGL=%b expected EGL=%b", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_cmp(input longint a, input longint b);
        if (a == b)     return c_E;
        else if (a > b) return c_G;
        else            return c_L;
    endfunction

    function automatic logic [2:0] egl_u4();
        return {bus_u4.E, bus_u4.G, bus_u4.L};
    endfunction
    function automatic logic [2:0] egl_s4();
        return {bus_s4.E, bus_s4.G, bus_s4.L};
    endfunction
    function automatic logic [2:0] egl_u8();
        return {bus_u8.E, bus_u8.G, bus_u8.L};
    endfunction

    // Same operands to the unsigned and signed 4-bit instances.
    task automatic step4(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] exp_u, input logic [2:0] exp_s);
        @(negedge clk);
        bus_u4.A = a; bus_u4.B = b;
        bus_s4.A = a; bus_s4.B = b;
        @(posedge clk);
        #1;
        check({tag, "/u4"}, egl_u4(), exp_u);
        check({tag, "/s4"}, egl_s4(), exp_s);
    endtask

    task automatic step8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] exp_u);
        @(negedge clk);
        bus_u8.A = a; bus_u8.B = b;
        @(posedge clk);
        #1;
        check({tag, "/u8"}, egl_u8(), exp_u);
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] ra8;
        logic [7:0] rb8;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus_u4.A = '0; bus_u4.B = '0;
        bus_s4.A = '0; bus_s4.B = '0;
        bus_u8.A = '0; bus_u8.B = '0;

        // Reset held across edges: outputs stay in the "no result" state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_u4", egl_u4(), c_NONE);
        check("reset_s4", egl_s4(), c_NONE);
        check("reset_u8", egl_u8(), c_NONE);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_pre_edge", egl_u4(), c_NONE);
        @(posedge clk);
        #1;
        check("release_first_u4", egl_u4(), c_E);
        check("release_first_s4", egl_s4(), c_E);
        check("release_first_u8", egl_u8(), c_E);

        // Back-to-back vectors, one result per cycle.
        step4("seq0", 4'b0100, 4'b0101, c_L, c_L);
        step4("seq1", 4'b1100, 4'b1111, c_L, c_L);
        step4("seq2", 4'b0110, 4'b0111, c_L, c_L);
        step4("seq3", 4'b1110, 4'b1101, c_G, c_G);

        // Latency: a new operand must not show before the next edge.
        @(negedge clk);
        bus_u4.A = 4'h0; bus_u4.B = 4'h9;
        bus_s4.A = 4'h0; bus_s4.B = 4'h9;
        #1;
        check("latency_hold_u4", egl_u4(), c_G);
        @(posedge clk);
        #1;
        check("latency_new_u4", egl_u4(), c_L);
        check("latency_new_s4", egl_s4(), c_G);

        step4("max_vs_0",   4'hF, 4'h0, c_G, c_L);
        step4("0_vs_max",   4'h0, 4'hF, c_L, c_G);
        step4("ones_ones",  4'hF, 4'hF, c_E, c_E);
        step4("8_vs_7",     4'h8, 4'h7, c_G, c_L);
        step4("7_vs_8",     4'h7, 4'h8, c_L, c_G);
        step4("zero_zero",  4'h0, 4'h0, c_E, c_E);
        step4("1_vs_0",     4'h1, 4'h0, c_G, c_G);
        step4("m2_vs_m3",   4'b1110, 4'b1101, c_G, c_G);

        step8("u8_ones",    8'hFF, 8'hFF, c_E);
        step8("u8_max_0",   8'hFF, 8'h00, c_G);
        step8("u8_80_7f",   8'h80, 8'h7F, c_G);
        step8("u8_lsb",     8'h5A, 8'h5B, c_L);

        // Asynchronous reset between edges, then resume.
        step4("pre_reset", 4'hC, 4'h3, c_G, c_L);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_u4", egl_u4(), c_NONE);
        check("async_reset_s4", egl_s4(), c_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_pre_edge", egl_u4(), c_NONE);
        @(posedge clk);
        #1;
        check("resume_u4", egl_u4(), c_G);
        check("resume_s4", egl_s4(), c_L);

        // Random cross-check against an integer reference, one-cycle delay.
        for (int k = 0; k < 1000; k++) begin
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            ra8 = 8'($urandom_range(0, 255));
            rb8 = 8'($urandom_range(0, 255));
            if (k % 8 == 0) rb  = ra;
            if (k % 8 == 4) rb8 = ra8;
            @(negedge clk);
            bus_u4.A = ra;  bus_u4.B = rb;
            bus_s4.A = ra;  bus_s4.B = rb;
            bus_u8.A = ra8; bus_u8.B = rb8;
            @(posedge clk);
            #1;
            check("rand_u4", egl_u4(), ref_cmp(longint'(ra), longint'(rb)));
            check("rand_s4", egl_s4(), ref_cmp(longint'($signed(ra)), longint'($signed(rb))));
            check("rand_u8", egl_u8(), ref_cmp(longint'(ra8), longint'(rb8)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
